// File: rtl/serial_window_quantizer_if.sv
// Beat/result bundle for serial_window_quantizer: serial beats in, one
// quantized result per word out.
interface serial_window_quantizer_if #(
    parameter int NUM_CH   = 4,
    parameter int OUT_BITS = 8,
    parameter int SEL_W    = 5
);
    logic [SEL_W-1:0]           start_bit;
    logic                       in_valid;
    logic                       in_first;
    logic [NUM_CH-1:0]          data_in;
    logic                       out_valid;
    logic [NUM_CH*OUT_BITS-1:0] out_data;
    logic [NUM_CH-1:0]          out_sat;

    modport master (
        output start_bit, in_valid, in_first, data_in,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  start_bit, in_valid, in_first, data_in,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/serial_window_quantizer.sv
// Multi-channel bit-serial quantizer: captures an OUT_BITS window of each
// LSB-first word, optionally rounds on the bit below it, saturates on overflow.
module serial_window_quantizer #(
    parameter int NUM_CH   = 4,
    parameter int IN_BITS  = 24,
    parameter int OUT_BITS = 8,
    parameter int ROUND    = 0,
    parameter int SEL_W    = $clog2(IN_BITS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_window_quantizer_if.slave bus
);
    localparam int XW = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                             state_r;
    logic [SEL_W-1:0]                   bit_idx_r;
    logic [SEL_W-1:0]                   win_lo_r;
    logic [NUM_CH-1:0][OUT_BITS-1:0]    cap_r;
    logic [NUM_CH-1:0]                  rnd_r;
    logic [NUM_CH-1:0]                  ovf_r;
    logic                               out_valid_r;
    logic [NUM_CH*OUT_BITS-1:0]         out_data_r;
    logic [NUM_CH-1:0]                  out_sat_r;

    logic                               beat_first_s;
    logic                               last_s;
    logic [XW-1:0]                      k_s;
    logic [XW-1:0]                      w_s;
    logic [OUT_BITS-1:0]                win_hit_s;
    logic                               rnd_hit_s;
    logic                               ovf_hit_s;
    logic [NUM_CH-1:0][OUT_BITS-1:0]    base_cap_s;
    logic [NUM_CH-1:0]                  base_rnd_s;
    logic [NUM_CH-1:0]                  base_ovf_s;
    logic [NUM_CH-1:0][OUT_BITS-1:0]    cap_n_s;
    logic [NUM_CH-1:0]                  rnd_n_s;
    logic [NUM_CH-1:0]                  ovf_n_s;
    logic [NUM_CH-1:0][OUT_BITS-1:0]    fin_data_s;
    logic [NUM_CH-1:0]                  fin_sat_s;

    // Returns {sat, value}: window plus round bit, clamped to all ones.
    function automatic logic [OUT_BITS:0] quantize(
        input logic [OUT_BITS-1:0] cap,
        input logic                rnd,
        input logic                ovf
    );
        logic [OUT_BITS:0] sum;
        logic              sat;
        sum = {1'b0, cap} + {{OUT_BITS{1'b0}}, rnd};
        sat = ovf | sum[OUT_BITS];
        quantize = {sat, (sat ? {OUT_BITS{1'b1}} : sum[OUT_BITS-1:0])};
    endfunction

    // Next-state of the per-channel capture for the beat currently presented.
    always_comb begin
        beat_first_s = bus.in_valid & bus.in_first;
        last_s       = (bit_idx_r == SEL_W'(IN_BITS - 1));
        // A first beat is bit 0 of a fresh word, so it sees cleared capture state.
        if (beat_first_s) begin
            k_s        = '0;
            w_s        = XW'(bus.start_bit);
            base_cap_s = '0;
            base_rnd_s = '0;
            base_ovf_s = '0;
        end else begin
            k_s        = XW'(bit_idx_r);
            w_s        = XW'(win_lo_r);
            base_cap_s = cap_r;
            base_rnd_s = rnd_r;
            base_ovf_s = ovf_r;
        end
        win_hit_s = '0;
        for (int p = 0; p < OUT_BITS; p++) begin
            win_hit_s[p] = (k_s == w_s + XW'(p));
        end
        rnd_hit_s = (ROUND != 0) && (w_s != '0) && (k_s + XW'(1) == w_s);
        ovf_hit_s = (k_s >= w_s + XW'(OUT_BITS));
        cap_n_s    = '0;
        rnd_n_s    = '0;
        ovf_n_s    = '0;
        fin_data_s = '0;
        fin_sat_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cap_n_s[c] = (base_cap_s[c] & ~win_hit_s) |
                         ({OUT_BITS{bus.data_in[c]}} & win_hit_s);
            rnd_n_s[c] = rnd_hit_s ? bus.data_in[c] : base_rnd_s[c];
            ovf_n_s[c] = base_ovf_s[c] | (ovf_hit_s & bus.data_in[c]);
            {fin_sat_s[c], fin_data_s[c]} = quantize(cap_n_s[c], rnd_n_s[c], ovf_n_s[c]);
        end
    end

    // Word framing FSM with registered result stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            bit_idx_r   <= '0;
            win_lo_r    <= '0;
            cap_r       <= '0;
            rnd_r       <= '0;
            ovf_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= '0;
        end else begin
            out_valid_r <= 1'b0;
            if (beat_first_s) begin
                // Starting a word also aborts any word in flight.
                state_r   <= SHIFT;
                win_lo_r  <= bus.start_bit;
                bit_idx_r <= SEL_W'(1);
                cap_r     <= cap_n_s;
                rnd_r     <= rnd_n_s;
                ovf_r     <= ovf_n_s;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    SHIFT: begin
                        if (bus.in_valid) begin
                            cap_r <= cap_n_s;
                            rnd_r <= rnd_n_s;
                            ovf_r <= ovf_n_s;
                            if (last_s) begin
                                out_valid_r <= 1'b1;
                                out_data_r  <= fin_data_s;
                                out_sat_r   <= fin_sat_s;
                                bit_idx_r   <= '0;
                                state_r     <= IDLE;
                            end else begin
                                bit_idx_r <= bit_idx_r + SEL_W'(1);
                            end
                        end else begin
                            state_r <= SHIFT;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;
endmodule

// File: tb/tb_serial_window_quantizer.sv
// Scoreboard bench: truncating and rounding instances share one stimulus
// stream; expected results come from an arithmetic word-level model.
module tb_serial_window_quantizer;
    localparam int NCH = 2;
    localparam int IB  = 16;
    localparam int OB  = 8;
    localparam int SW  = 4;

    typedef struct {
        logic [NCH*OB-1:0] data;
        logic [NCH-1:0]    sat;
        int                t;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ncount;
    exp_t exp_q [2][$];

    serial_window_quantizer_if #(.NUM_CH(NCH), .OUT_BITS(OB), .SEL_W(SW)) bus0 ();
    serial_window_quantizer_if #(.NUM_CH(NCH), .OUT_BITS(OB), .SEL_W(SW)) bus1 ();

    serial_window_quantizer #(.NUM_CH(NCH), .IN_BITS(IB), .OUT_BITS(OB), .ROUND(0), .SEL_W(SW))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    serial_window_quantizer #(.NUM_CH(NCH), .IN_BITS(IB), .OUT_BITS(OB), .ROUND(1), .SEL_W(SW))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: slice, round, saturate with plain integer arithmetic.
    function automatic void model(input int sb, input logic [15:0] w, input bit rnd,
                                  output logic [7:0] d, output logic s);
        int unsigned word;
        int unsigned win;
        int unsigned r;
        int unsigned sum;
        bit          above;
        word  = 32'(w);
        win   = (word >> sb) & 32'd255;
        r     = (rnd && sb > 0) ? ((word >> (sb - 1)) & 32'd1) : 32'd0;
        above = (word >> (sb + 8)) != 32'd0;
        sum   = win + r;
        s     = above || (sum > 32'd255);
        d     = s ? 8'hFF : sum[7:0];
    endfunction

    task automatic set_in(input logic v, input logic f, input logic [NCH-1:0] d,
                          input logic [SW-1:0] sb);
        bus0.in_valid = v;  bus1.in_valid = v;
        bus0.in_first = f;  bus1.in_first = f;
        bus0.data_in  = d;  bus1.data_in  = d;
        bus0.start_bit = sb; bus1.start_bit = sb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'($urandom), 2'($urandom), 4'($urandom));
            @(posedge clk); #1;
        end
    endtask

    task automatic push_expect(input int sb, input logic [15:0] w0, input logic [15:0] w1);
        exp_t       e;
        logic [7:0] d0, d1;
        logic       s0, s1;
        for (int i = 0; i < 2; i++) begin
            model(sb, w0, i[0], d0, s0);
            model(sb, w1, i[0], d1, s1);
            e.data = {d1, d0};
            e.sat  = {s1, s0};
            e.t    = ncount + 2;
            exp_q[i].push_back(e);
        end
    endtask

    // cut_at < 16 stops the word early (abort, or reset when rst_cut is set).
    task automatic send_word(input int sb, input logic [15:0] w0, input logic [15:0] w1,
                             input int stall_at, input int stall_len,
                             input int cut_at, input bit rst_cut);
        for (int k = 0; k < IB; k++) begin
            if (k == cut_at) begin
                if (rst_cut) begin
                    rst_n = 1'b0;
                    set_in(1'b0, 1'b0, 2'b00, 4'd0);
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                end
                set_in(1'b0, 1'b0, 2'b00, 4'd0);
                return;
            end
            if (k == stall_at) idle(stall_len);
            set_in(1'b1, (k == 0), {w1[k], w0[k]}, (k == 0) ? 4'(sb) : 4'($urandom));
            if (k == IB - 1) push_expect(sb, w0, w1);
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, 2'b00, 4'd0);
    endtask

    // Monitor: checks pulses against the scoreboard and output hold between pulses.
    initial begin
        logic              rst_q;
        logic              ov;
        logic [NCH*OB-1:0] od;
        logic [NCH-1:0]    os;
        logic [NCH*OB-1:0] held_d [2];
        logic [NCH-1:0]    held_s [2];
        exp_t              e;
        held_d[0] = '0; held_d[1] = '0;
        held_s[0] = '0; held_s[1] = '0;
        forever begin
            @(posedge clk);
            rst_q = rst_n;
            @(negedge clk);
            ncount++;
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin ov = bus0.out_valid; od = bus0.out_data; os = bus0.out_sat; end
                else        begin ov = bus1.out_valid; od = bus1.out_data; os = bus1.out_sat; end
                if (!rst_q) begin
                    chk("reset_valid", 32'(ov), 32'd0);
                    chk("reset_data", 32'(od), 32'd0);
                    chk("reset_sat", 32'(os), 32'd0);
                    held_d[i] = '0;
                    held_s[i] = '0;
                end else if (ov === 1'b1) begin
                    checks++;
                    if (exp_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse dut%0d actual=1 expected=0 at t=%0t", i, $time);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk(i ? "data_rnd" : "data_trunc", 32'(od), 32'(e.data));
                        chk(i ? "sat_rnd" : "sat_trunc", 32'(os), 32'(e.sat));
                        chk("latency", 32'(ncount), 32'(e.t));
                        held_d[i] = e.data;
                        held_s[i] = e.sat;
                    end
                end else begin
                    chk("valid_low", 32'(ov), 32'd0);
                    chk("hold_data", 32'(od), 32'(held_d[i]));
                    chk("hold_sat", 32'(os), 32'(held_s[i]));
                end
            end
        end
    end

    initial begin
        logic [15:0] a, b;
        int sb, st, sl, cut;
        checks = 0;
        errors = 0;
        ncount = 0;
        rst_n  = 1'b0;
        set_in(1'b0, 1'b0, 2'b00, 4'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        send_word(4, 16'h0AB0, 16'h0050, -1, 0, 16, 1'b0);   // truncate
        idle(3);
        send_word(4, 16'h1AB0, 16'h0FF0, -1, 0, 16, 1'b0);   // overflow saturation
        idle(2);
        send_word(4, 16'h0AB8, 16'h0FF8, -1, 0, 16, 1'b0);   // rounding and carry-out
        send_word(0, 16'h00FF, 16'h0100, -1, 0, 16, 1'b0);   // no round bit below bit 0
        idle(2);
        send_word(12, 16'hF000, 16'h8000, -1, 0, 16, 1'b0);  // window past the word
        idle(2);
        send_word(12, 16'hF000, 16'h8000, 6, 3, 16, 1'b0);   // stalled copy
        idle(2);
        send_word(4, 16'h1234, 16'h5678, -1, 0, 7, 1'b0);    // aborted word A
        send_word(4, 16'h0AB0, 16'h0050, -1, 0, 16, 1'b0);   // B
        send_word(4, 16'h0CD0, 16'h1110, -1, 0, 16, 1'b0);   // C back-to-back
        idle(2);
        for (int i = 0; i < 5; i++) begin                    // stray beats in IDLE
            set_in(1'b1, 1'b0, 2'($urandom), 4'($urandom));
            @(posedge clk); #1;
        end
        idle(2);
        send_word(4, 16'hFFFF, 16'hFFFF, -1, 0, 5, 1'b1);    // reset mid-word
        idle(2);
        send_word(4, 16'h0AB0, 16'h00F0, -1, 0, 16, 1'b0);
        idle(2);

        for (int n = 0; n < 40; n++) begin
            sb  = $urandom_range(0, 15);
            a   = 16'($urandom) >> $urandom_range(0, 15);
            b   = 16'($urandom) >> $urandom_range(0, 15);
            st  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
            sl  = $urandom_range(1, 4);
            cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 16;
            send_word(sb, a, b, st, sl, cut, 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(6);
        chk("leftover_trunc", 32'(exp_q[0].size()), 32'd0);
        chk("leftover_rnd", 32'(exp_q[1].size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_window_quantizer.md
# serial_window_quantizer

Multi-channel bit-serial activation quantizer for the activation-quantization path. Each channel receives an unsigned accumulator word LSB-first, one bit per accepted beat. The block captures an OUT_BITS-wide window that starts at a runtime-selectable bit index. It optionally rounds the window on the bit below it and saturates when any bit above the window is set. All channels share framing and finish together, so one valid pulse carries every channel's quantized result.

## Interface
Parameters:
- NUM_CH, 4, number of parallel serial channels
- IN_BITS, 24, serial word length in bits (≥ OUT_BITS+1)
- OUT_BITS, 8, captured window width
- ROUND, 0, 1 = round-half-up on bit (start_bit-1); 0 = truncate
- SEL_W, $clog2(IN_BITS), width of bit-index fields

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: synchronous, active-low
- start_bit  in  SEL_W  window LSB index, sampled on the first beat of a word
- in_valid  in  1  beat qualifier; data_in is ignored when low
- in_first  in  1  with in_valid: this beat is bit 0 of a new word
- data_in  in  NUM_CH  one serial bit per channel (bit c = channel c)
- out_valid  out  1  one-cycle pulse: out_data/out_sat are new
- out_data  out  NUM_CH*OUT_BITS  channel c at [c*OUT_BITS +: OUT_BITS]
- out_sat  out  NUM_CH  channel c result was saturated

## Operation
- States:
  - IDLE: waiting for a word.
  - SHIFT: word in progress.
  - A registered output stage sits behind both.
- IDLE → SHIFT on a beat with in_valid & in_first. That beat is bit index 0. The block latches start_bit into win_lo and clears all per-channel capture, round and overflow registers.
- In SHIFT, each in_valid beat advances bit index k by 1. For beat k, per channel:
  - k in [win_lo, win_lo+OUT_BITS-1]: the bit is stored at capture position k-win_lo.
  - k == win_lo-1, with ROUND=1 and win_lo>0: the bit is stored as that channel's round bit.
  - k > win_lo+OUT_BITS-1: the bit is ORed into that channel's sticky overflow flag.
  - k < win_lo-1: the bit is discarded.
- Window bits at index ≥ IN_BITS are never received and read as 0. This applies when win_lo > IN_BITS-OUT_BITS.
- At k == IN_BITS-1 the block finalizes every channel:
  - sum = capture + round_bit, computed (OUT_BITS+1) bits wide.
  - sat = overflow | sum[OUT_BITS].
  - out_data channel = sat ? all ones : sum[OUT_BITS-1:0].
  - The state returns to IDLE.
- A beat with in_valid & in_first while in SHIFT aborts the current word and produces no output. That beat starts a new word (same actions as IDLE → SHIFT).
- In IDLE, a beat with in_valid & ~in_first is ignored.
- start_bit changes mid-word have no effect until the next in_first.

## Timing
- Reset (rst_n low at a rising edge) returns the block to IDLE and clears these registers:
  - bit index
  - win_lo
  - capture, round and overflow registers
  - out_valid=0, out_data=0, out_sat=0
- Reset mid-word discards the word; no output is produced for it.
- Latency: out_valid is high for exactly one cycle, on the cycle after the edge that accepts beat IN_BITS-1. out_data and out_sat update in the same cycle.
- out_data and out_sat hold their values until the next out_valid or reset.
- There is no backpressure; the consumer must take the result on the out_valid pulse.
- Stalls: in_valid low beats do not advance k. The output is delayed by exactly the number of stall cycles.
- Back-to-back words are supported. in_first may be accepted on the cycle right after the last beat of the previous word. The previous word's out_valid still fires, and the new word is unaffected.
- Minimum word period is IN_BITS cycles; full throughput is one result per IN_BITS beats.

## Test plan
All scenarios use IN_BITS=16, OUT_BITS=8, NUM_CH=2. Words are sent LSB-first.

- Truncate: ROUND=0, start_bit=4, ch0=0x0AB0, ch1=0x0050 → out_data={0x05,0xAB}, out_sat=00. out_valid pulses 1 cycle after beat 15.
- Saturate on overflow: ROUND=0, start_bit=4, ch0=0x1AB0 (bit 12 set) → ch0=0xFF, out_sat[0]=1. ch1=0x0FF0 → ch1=0xFF, out_sat[1]=0.
- Rounding: ROUND=1, start_bit=4.
  - ch0=0x0AB8 → 0xAC, sat 0.
  - ch1=0x0FF8 (carry out) → 0xFF, sat 1.
  - start_bit=0 with ch0=0x00FF → 0xFF, no round applied.
- High window / stall: start_bit=12, ch0=0xF000 → 0x0F (bits 16..19 read 0). Inserting 3 in_valid-low cycles at beat 6 delays out_valid by exactly 3 cycles with the same data.
- Abort and back-to-back:
  - in_first reasserted at beat 7 of word A → no out_valid for A. The following word B (0x0AB0, start 4) → 0xAB.
  - Word C starting the cycle after B's last beat → both B and C outputs are correct, exactly 16 cycles apart.
- Reset mid-word: rst_n low for 1 cycle at beat 5 → out_valid, out_data and out_sat all 0 with no pulse. The next full word 0x0AB0 (start 4) → 0xAB.
